// File: rtl/sr_mem_ctrl_pkg.sv
// sr_mem_ctrl_pkg: AGU request codes shared with the CPU and address-window helpers.
package sr_mem_ctrl_pkg;
    localparam logic [2:0] AGU_IDLE  = 3'd0;
    localparam logic [2:0] AGU_LOAD  = 3'd1;
    localparam logic [2:0] AGU_STORE = 3'd2;
    localparam int DATA_W = 32;

    function automatic logic [31:0] wordSpan(input int addrW);
        return 32'd4 << addrW;
    endfunction
endpackage

// File: rtl/sr_store_buffer.sv
// sr_store_buffer: posted-store FIFO of {word index, data}; callers gate push with full and pop with empty.
module sr_store_buffer
    import sr_mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [ADDR_W-1:0] pushIndex,
    input  logic [DATA_W-1:0] pushData,
    input  logic              pop,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W-1:0] headIndex,
    output logic [DATA_W-1:0] headData
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [ADDR_W-1:0] idxMem [DEPTH];
    logic [DATA_W-1:0] dataMem [DEPTH];
    logic [PTR_W-1:0]  wrPtr, rdPtr;
    logic [PTR_W:0]    count;

    assign full      = count == (PTR_W+1)'(DEPTH);
    assign empty     = count == '0;
    assign headIndex = idxMem[rdPtr];
    assign headData  = dataMem[rdPtr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + 1'b1;
            if (pop) rdPtr <= rdPtr + 1'b1;
            count <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            idxMem[wrPtr]  <= pushIndex;
            dataMem[wrPtr] <= pushData;
        end
    end
endmodule

// File: rtl/sr_mem_ctrl.sv
// sr_mem_ctrl: per-core data-memory controller with never-stalling posted stores and
// loads that wait for the store buffer to drain so they always observe earlier stores.
module sr_mem_ctrl
    import sr_mem_ctrl_pkg::*;
#(
    parameter int          ADDR_W    = 10,
    parameter int          SB_DEPTH  = 2,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  aguInstructionOut,
    input  logic [31:0] ramAddress,
    input  logic [31:0] dataFromCpu,
    output logic [31:0] dataToCpu,
    output logic        dataReceived,
    output logic        sbOverflow,
    output logic        addrError
);
    typedef enum logic [1:0] {IDLE, READ, RESP} state_t;

    state_t            state;
    logic [31:0]       offset;
    logic [ADDR_W-1:0] index, headIndex;
    logic [31:0]       headData, ramQ;
    logic              inRange, isLoad, isStore, sbFull, sbEmpty, sbPush, sbPop, loadOob;
    logic [31:0]       ram [2**ADDR_W];

    assign offset  = ramAddress - BASE_ADDR;
    assign inRange = offset < wordSpan(ADDR_W);
    assign index   = offset[ADDR_W+1:2];
    assign isLoad  = aguInstructionOut == AGU_LOAD;
    assign isStore = aguInstructionOut == AGU_STORE;
    assign sbPush  = isStore && inRange && !sbFull;
    assign sbPop   = !sbEmpty && state != READ;

    sr_store_buffer #(.ADDR_W(ADDR_W), .DEPTH(SB_DEPTH)) storeBuffer (
        .clk(clk),
        .rst(rst),
        .push(sbPush),
        .pushIndex(index),
        .pushData(dataFromCpu),
        .pop(sbPop),
        .full(sbFull),
        .empty(sbEmpty),
        .headIndex(headIndex),
        .headData(headData)
    );

    // Single port: the drain write wins; the load read is taken on the IDLE->READ edge,
    // when the buffer is empty and no write can collide.
    always_ff @(posedge clk) begin
        if (sbPop) ram[headIndex] <= headData;
        else if (state == IDLE) ramQ <= ram[index];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            loadOob      <= 1'b0;
            dataToCpu    <= '0;
            dataReceived <= 1'b0;
            sbOverflow   <= 1'b0;
            addrError    <= 1'b0;
        end else begin
            dataReceived <= state == READ;
            if (isStore && inRange && sbFull) sbOverflow <= 1'b1;
            if (isStore && !inRange) addrError <= 1'b1;
            unique case (state)
                IDLE: if (isLoad && sbEmpty) begin
                    state   <= READ;
                    loadOob <= !inRange;
                end
                READ: begin
                    state     <= RESP;
                    dataToCpu <= loadOob ? '0 : ramQ;
                    if (loadOob) addrError <= 1'b1;
                end
                RESP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sr_mem_ctrl.sv
// tb_sr_mem_ctrl: directed-vector bench for sr_mem_ctrl with hand-computed expectations.
module tb_sr_mem_ctrl;
    import sr_mem_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  aguInstructionOut;
    logic [31:0] ramAddress, dataFromCpu, dataToCpu;
    logic        dataReceived, sbOverflow, addrError;
    int          errors = 0;
    int          checks = 0;

    sr_mem_ctrl dut (
        .clk(clk),
        .rst(rst),
        .aguInstructionOut(aguInstructionOut),
        .ramAddress(ramAddress),
        .dataFromCpu(dataFromCpu),
        .dataToCpu(dataToCpu),
        .dataReceived(dataReceived),
        .sbOverflow(sbOverflow),
        .addrError(addrError)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic doStore(input logic [31:0] addr, input logic [31:0] data);
        aguInstructionOut = AGU_STORE;
        ramAddress = addr;
        dataFromCpu = data;
        @(negedge clk);
        aguInstructionOut = AGU_IDLE;
    endtask

    task automatic doLoad(input string tag, input logic [31:0] addr, input logic [31:0] expData, input int expLat);
        int lat = 0;
        aguInstructionOut = AGU_LOAD;
        ramAddress = addr;
        do begin
            @(negedge clk);
            lat++;
        end while (!dataReceived && lat < 8);
        chk({tag, " latency"}, 32'(lat), 32'(expLat));
        chk({tag, " data"}, dataToCpu, expData);
        aguInstructionOut = AGU_IDLE;
        @(negedge clk);
        chk({tag, " strobe once"}, 32'(dataReceived), 32'd0);
        chk({tag, " data hold"}, dataToCpu, expData);
    endtask

    initial begin
        rst = 1'b1;
        aguInstructionOut = AGU_IDLE;
        ramAddress = '0;
        dataFromCpu = '0;
        repeat (2) @(negedge clk);
        chk("reset dataToCpu", dataToCpu, 32'd0);
        chk("reset dataReceived", 32'(dataReceived), 32'd0);
        chk("reset sbOverflow", 32'(sbOverflow), 32'd0);
        chk("reset addrError", 32'(addrError), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        doStore(32'h10, 32'hDEADBEEF);
        doLoad("store-then-load", 32'h10, 32'hDEADBEEF, 3);

        doStore(32'h50, 32'hCAFEF00D);
        repeat (2) @(negedge clk);
        doLoad("preloaded", 32'h50, 32'hCAFEF00D, 2);

        doStore(32'h0, 32'd1);
        doStore(32'h4, 32'd2);
        doStore(32'h8, 32'd3);
        chk("three stores no overflow", 32'(sbOverflow), 32'd0);
        doLoad("word0", 32'h0, 32'd1, 3);
        doLoad("word1", 32'h4, 32'd2, 2);
        doLoad("word2", 32'h8, 32'd3, 2);
        chk("still no overflow", 32'(sbOverflow), 32'd0);

        force dut.sbFull = 1'b1;
        doStore(32'h0, 32'h99);
        release dut.sbFull;
        @(negedge clk);
        chk("overflow set", 32'(sbOverflow), 32'd1);
        repeat (3) @(negedge clk);
        chk("overflow sticky", 32'(sbOverflow), 32'd1);
        doLoad("dropped store", 32'h0, 32'd1, 2);

        chk("addrError clear", 32'(addrError), 32'd0);
        doLoad("oob load", 32'h0001_0000, 32'd0, 2);
        chk("addrError oob load", 32'(addrError), 32'd1);
        doStore(32'h0001_0000, 32'h55);
        @(negedge clk);
        doLoad("oob store ignored", 32'h0, 32'd1, 2);

        aguInstructionOut = AGU_LOAD;
        ramAddress = 32'h10;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midread rst dataToCpu", dataToCpu, 32'd0);
        chk("midread rst dataReceived", 32'(dataReceived), 32'd0);
        chk("midread rst sbOverflow", 32'(sbOverflow), 32'd0);
        chk("midread rst addrError", 32'(addrError), 32'd0);
        aguInstructionOut = AGU_IDLE;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post rst no strobe", 32'(dataReceived), 32'd0);
        doLoad("ram survives rst", 32'h10, 32'hDEADBEEF, 2);

        doStore(32'h2000, 32'h77);
        @(negedge clk);
        chk("addrError oob store", 32'(addrError), 32'd1);
        chk("no overflow after oob store", 32'(sbOverflow), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
